// File: rtl/demux_1x4_dispatcher.sv
// demux_1x4_dispatcher: valid/ready 1-to-4 dispatcher with a single registered
// holding stage. Beats are steered by in_dest (RR_MODE=0) or by round-robin
// over the enabled channels (RR_MODE=1).
// Optional macro DEMUX_DISP_STATS_EN adds saturating per-channel completion
// counters, a drop counter and a synchronous stat_clr input.
module demux_1x4_dispatcher #(
  parameter int unsigned W       = 8,
  parameter int unsigned RR_MODE = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [3:0]   chan_en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_dest,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [W-1:0] out_data,
  output logic         drop,
  output logic         busy
`ifdef DEMUX_DISP_STATS_EN
  ,
  output logic [15:0]  stat_cnt0,
  output logic [15:0]  stat_cnt1,
  output logic [15:0]  stat_cnt2,
  output logic [15:0]  stat_cnt3,
  output logic [15:0]  drop_cnt,
  input  logic         stat_clr
`endif
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [1:0]     tgt_q, tgt_d;
  logic [W-1:0]   data_q, data_d;
  logic [1:0]     rr_ptr_q, rr_ptr_d;
  logic [3:0]     out_valid_q, out_valid_d;
  logic           drop_q, drop_d;
  logic           busy_q;
  logic [1:0]     sel_tgt;
  logic [1:0]     idx;
  logic           accept;
  logic           complete;

  // Target selection: routed by in_dest, or first enabled channel at/after rr_ptr.
  always_comb begin
    sel_tgt = in_dest;
    idx     = 2'd0;
    if (RR_MODE != 0) begin
      sel_tgt = rr_ptr_q;
      for (int i = 3; i >= 0; i--) begin
        idx = 2'(rr_ptr_q + 2'(i));
        if (chan_en[idx]) sel_tgt = idx;
      end
    end
  end

  // Next-state, handshake and holding-register update.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    data_d      = data_q;
    rr_ptr_d    = rr_ptr_q;
    drop_d      = 1'b0;
    out_valid_d = 4'b0000;
    // With no channel enabled a round-robin beat has nowhere to go, so hold it off.
    if (state_q == FULL) in_ready = out_ready[tgt_q] && ((RR_MODE == 0) || (|chan_en));
    else                 in_ready = (RR_MODE == 0) || (|chan_en);
    accept   = in_valid && in_ready;
    complete = (state_q == FULL) && out_ready[tgt_q];
    if (complete) state_d = EMPTY;
    if (accept) begin
      if (chan_en[sel_tgt]) begin
        state_d = FULL;
        tgt_d   = sel_tgt;
        data_d  = in_data;
        if (RR_MODE != 0) rr_ptr_d = 2'(sel_tgt + 2'd1);
      end else begin
        drop_d = 1'b1;
      end
    end
    if (state_d == FULL) out_valid_d = 4'b0001 << tgt_d;
  end

  // State and output registers; reset discards any held beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= EMPTY;
      tgt_q       <= 2'd0;
      data_q      <= '0;
      rr_ptr_q    <= 2'd0;
      out_valid_q <= 4'b0000;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      data_q      <= data_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
      busy_q      <= (state_d == FULL);
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign drop      = drop_q;
  assign busy      = busy_q;

`ifdef DEMUX_DISP_STATS_EN
  logic [CNT_W-1:0] stat_q [4];
  logic [CNT_W-1:0] drop_cnt_q;

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 4; k++) stat_q[k] <= '0;
      drop_cnt_q <= '0;
    end else if (stat_clr) begin
      for (int k = 0; k < 4; k++) stat_q[k] <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (complete && (stat_q[tgt_q] != {CNT_W{1'b1}}))
        stat_q[tgt_q] <= stat_q[tgt_q] + CNT_W'(1);
      if (drop_d && (drop_cnt_q != {CNT_W{1'b1}}))
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign stat_cnt0 = stat_q[0];
  assign stat_cnt1 = stat_q[1];
  assign stat_cnt2 = stat_q[2];
  assign stat_cnt3 = stat_q[3];
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_1x4_dispatcher.sv
// Directed bench for demux_1x4_dispatcher: one routed instance and one
// round-robin instance sharing clock and reset.
module tb_demux_1x4_dispatcher;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rstn;

  logic [3:0]   rt_chan_en, rt_out_ready, rt_out_valid;
  logic         rt_in_valid, rt_in_ready, rt_drop, rt_busy;
  logic [W-1:0] rt_in_data, rt_out_data;
  logic [1:0]   rt_in_dest;

  logic [3:0]   rr_chan_en, rr_out_ready, rr_out_valid;
  logic         rr_in_valid, rr_in_ready, rr_drop, rr_busy;
  logic [W-1:0] rr_in_data, rr_out_data;
  logic [1:0]   rr_in_dest;

`ifdef DEMUX_DISP_STATS_EN
  logic [15:0]  rt_s0, rt_s1, rt_s2, rt_s3, rt_dcnt;
  logic [15:0]  rr_s0, rr_s1, rr_s2, rr_s3, rr_dcnt;
  logic         rt_stat_clr, rr_stat_clr;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  demux_1x4_dispatcher #(.W(W), .RR_MODE(0)) u_rt (
    .clk(clk), .rstn(rstn), .chan_en(rt_chan_en),
    .in_valid(rt_in_valid), .in_ready(rt_in_ready), .in_data(rt_in_data), .in_dest(rt_in_dest),
    .out_valid(rt_out_valid), .out_ready(rt_out_ready), .out_data(rt_out_data),
    .drop(rt_drop), .busy(rt_busy)
`ifdef DEMUX_DISP_STATS_EN
    , .stat_cnt0(rt_s0), .stat_cnt1(rt_s1), .stat_cnt2(rt_s2), .stat_cnt3(rt_s3),
    .drop_cnt(rt_dcnt), .stat_clr(rt_stat_clr)
`endif
  );

  demux_1x4_dispatcher #(.W(W), .RR_MODE(1)) u_rr (
    .clk(clk), .rstn(rstn), .chan_en(rr_chan_en),
    .in_valid(rr_in_valid), .in_ready(rr_in_ready), .in_data(rr_in_data), .in_dest(rr_in_dest),
    .out_valid(rr_out_valid), .out_ready(rr_out_ready), .out_data(rr_out_data),
    .drop(rr_drop), .busy(rr_busy)
`ifdef DEMUX_DISP_STATS_EN
    , .stat_cnt0(rr_s0), .stat_cnt1(rr_s1), .stat_cnt2(rr_s2), .stat_cnt3(rr_s3),
    .drop_cnt(rr_dcnt), .stat_clr(rr_stat_clr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rr_exp [6];
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd3;
    rr_exp[3] = 2'd0; rr_exp[4] = 2'd1; rr_exp[5] = 2'd3;

    rstn = 1'b0;
    rt_chan_en = 4'hF; rt_out_ready = 4'hF; rt_in_valid = 1'b0; rt_in_data = '0; rt_in_dest = 2'd0;
    rr_chan_en = 4'h0; rr_out_ready = 4'hF; rr_in_valid = 1'b0; rr_in_data = '0; rr_in_dest = 2'd0;
`ifdef DEMUX_DISP_STATS_EN
    rt_stat_clr = 1'b0; rr_stat_clr = 1'b0;
`endif
    #12 rstn = 1'b1;
    step();

    // Reset state
    check("rst_out_valid", 32'(rt_out_valid), 32'h0);
    check("rst_out_data",  32'(rt_out_data),  32'h0);
    check("rst_busy",      32'(rt_busy),      32'h0);
    check("rst_drop",      32'(rt_drop),      32'h0);
    check("rst_in_ready",  32'(rt_in_ready),  32'h1);
    check("rr_rst_in_ready_all_off", 32'(rr_in_ready), 32'h0);

    // Reset mid-transfer
    rt_in_valid = 1'b1; rt_in_data = 8'hA5; rt_in_dest = 2'd2; rt_out_ready = 4'h0;
    step();
    rt_in_valid = 1'b0;
    check("mid_out_valid", 32'(rt_out_valid), 32'h4);
    check("mid_out_data",  32'(rt_out_data),  32'hA5);
    check("mid_busy",      32'(rt_busy),      32'h1);
    rstn = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(rt_out_valid), 32'h0);
    check("async_rst_busy",      32'(rt_busy),      32'h0);
    #1 rstn = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(rt_in_ready), 32'h1);
    step();

    // Routed stream, one beat per cycle
    rt_out_ready = 4'hF;
    for (int i = 0; i < 8; i++) begin
      rt_in_valid = 1'b1; rt_in_data = 8'(i); rt_in_dest = 2'(i);
      #1;
      check($sformatf("stream_in_ready_%0d", i), 32'(rt_in_ready), 32'h1);
      step();
      check($sformatf("stream_valid_%0d", i), 32'(rt_out_valid), 32'(4'b0001 << (i % 4)));
      check($sformatf("stream_data_%0d", i),  32'(rt_out_data),  32'(i));
    end
    rt_in_valid = 1'b0;
    step();
    check("stream_drain_valid", 32'(rt_out_valid), 32'h0);
    check("stream_drain_busy",  32'(rt_busy),      32'h0);

    // Backpressure on channel 1
    rt_out_ready = 4'b1101;
    rt_in_valid = 1'b1; rt_in_data = 8'h3C; rt_in_dest = 2'd1;
    step();
    rt_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_%0d", i),    32'(rt_out_valid), 32'h2);
      check($sformatf("bp_data_%0d", i),     32'(rt_out_data),  32'h3C);
      check($sformatf("bp_in_ready_%0d", i), 32'(rt_in_ready),  32'h0);
      step();
    end
    rt_out_ready = 4'hF;
    #1;
    check("bp_release_in_ready", 32'(rt_in_ready), 32'h1);
    step();
    check("bp_done_valid", 32'(rt_out_valid), 32'h0);
    check("bp_done_busy",  32'(rt_busy),      32'h0);

    // Drop: channel 0 disabled, three separated beats
    rt_chan_en = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      rt_in_valid = 1'b1; rt_in_data = 8'(8'h50 + i); rt_in_dest = 2'd0;
      step();
      rt_in_valid = 1'b0;
      check($sformatf("drop_pulse_%0d", i), 32'(rt_drop),      32'h1);
      check($sformatf("drop_valid_%0d", i), 32'(rt_out_valid), 32'h0);
      check($sformatf("drop_busy_%0d", i),  32'(rt_busy),      32'h0);
      step();
      check($sformatf("drop_end_%0d", i), 32'(rt_drop), 32'h0);
    end
`ifdef DEMUX_DISP_STATS_EN
    check("stat_cnt0", 32'(rt_s0), 32'd2);
    check("stat_cnt1", 32'(rt_s1), 32'd3);
    check("stat_cnt2", 32'(rt_s2), 32'd2);
    check("stat_cnt3", 32'(rt_s3), 32'd2);
    check("drop_cnt",  32'(rt_dcnt), 32'd3);
    rt_stat_clr = 1'b1;
    step();
    rt_stat_clr = 1'b0;
    check("drop_cnt_clr",  32'(rt_dcnt), 32'd0);
    check("stat_cnt1_clr", 32'(rt_s1),   32'd0);
`endif
    rt_chan_en = 4'hF;

    // Round-robin with channel 2 skipped; in_dest is ignored
    rr_chan_en = 4'b1011; rr_in_dest = 2'd2;
    for (int i = 0; i < 6; i++) begin
      rr_in_valid = 1'b1; rr_in_data = 8'(8'h10 + i);
      #1;
      check($sformatf("rr_in_ready_%0d", i), 32'(rr_in_ready), 32'h1);
      step();
      check($sformatf("rr_valid_%0d", i), 32'(rr_out_valid), 32'(4'b0001 << rr_exp[i]));
      check($sformatf("rr_data_%0d", i),  32'(rr_out_data),  32'(8'h10 + i));
    end
    rr_in_valid = 1'b0;
    step();
    check("rr_drain_valid", 32'(rr_out_valid), 32'h0);

    // Round-robin with every channel disabled
    rr_chan_en = 4'b0000; rr_in_valid = 1'b1; rr_in_data = 8'h77;
    #1;
    check("rr_off_in_ready", 32'(rr_in_ready), 32'h0);
    step();
    step();
    check("rr_off_valid", 32'(rr_out_valid), 32'h0);
    check("rr_off_busy",  32'(rr_busy),      32'h0);
    check("rr_off_drop",  32'(rr_drop),      32'h0);
    // Pointer sits at 0 after target 3; the only enabled channel is 2
    rr_chan_en = 4'b0100;
    step();
    rr_in_valid = 1'b0;
    check("rr_resume_valid", 32'(rr_out_valid), 32'h4);
    check("rr_resume_data",  32'(rr_out_data),  32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
